hazard_ctrl: RTL

- Decode-stage hazard and sequencing controller for the 5-stage RV32I pipeline.
- Classifies the ID-stage instruction by opcode, using the same opcode set the immediate generator decodes, to find which source registers it reads.
- Detects load-use hazards and EX-stage redirects (taken branch, jal, jalr), and freezes the pipeline while a data-memory access waits for acknowledge.
- Drives the PC-write, IF/ID-write, flush and hold enables of the pipeline registers.

---
 rtl/hazard_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage hazard and sequencing controller for the 5-stage
// RV32I pipeline. Detects load-use hazards and EX redirects, and freezes the
// pipeline while a data-memory access waits for its acknowledge.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
module hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_hold,
  output logic             timeout_err,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
`endif
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_W = TIMEOUT[7:0];

  // Parameter legality is checked at elaboration time.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("hazard_ctrl: TIMEOUT must be in 2..255");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  state_t      state_reg, state_next;
  logic [7:0]  wait_reg, wait_next;
  logic        err_reg, err_next;

  logic [6:0]       opcode;
  logic [1:0][4:0]  src;
  logic [1:0]       src_used;
  logic [1:0]       src_hit;
  logic             load_use;
  logic             mem_stall;
  logic             unused_inst_bits;

  assign opcode           = id_inst[6:0];
  assign src[0]           = id_inst[19:15];
  assign src[1]           = id_inst[24:20];
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  // Which source fields the ID instruction actually reads, by opcode.
  always_comb begin
    src_used = 2'b00;
    case (opcode)
      7'b0100011, 7'b1100011, 7'b0110011: src_used = 2'b11;
      7'b0000011, 7'b0010011, 7'b1100111: src_used = 2'b01;
      default:                            src_used = 2'b00;
    endcase
  end

  // A used source matching the load destination; x0 is excluded via ex_rd below.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign src_hit[gi] = src_used[gi] && (src[gi] == ex_rd);
  end

  assign load_use  = ex_mem_read && (ex_rd != 5'd0) && (|src_hit);
  assign mem_stall = dmem_req && !dmem_ack;

  // Next-state and combinational pipeline enables from state and inputs.
  always_comb begin
    state_next  = state_reg;
    wait_next   = wait_reg;
    err_next    = err_reg;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_hold   = 1'b0;
    case (state_reg)
      RUN: begin
        if (mem_stall) begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          state_next  = MEM_WAIT;
          wait_next   = 8'd1;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          state_next  = LU_STALL;
        end
      end
      LU_STALL: begin
        // EX holds the bubble, so no hazard check this cycle.
        state_next = RUN;
        if (mem_stall) begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          state_next  = MEM_WAIT;
          wait_next   = 8'd1;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ack) begin
          // Release cycle: pending redirect or load-use is handled right away.
          state_next = RUN;
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_next  = LU_STALL;
          end
        end else if (wait_reg >= TIMEOUT_W) begin
          err_next   = 1'b1;
          state_next = RUN;
        end else begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          wait_next   = wait_reg + 8'd1;
        end
      end
      default: state_next = RUN;
    endcase
    // While in reset the pipeline registers are held flushed.
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      wait_reg  <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      err_reg   <= err_next;
    end
  end

  assign state       = state_reg;
  assign timeout_err = err_reg;

`ifdef HAZARD_PERF_EN
  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (!pc_write)              stall_cnt <= stall_cnt + CNT_W'(1);
      if (id_ex_flush)            flush_cnt <= flush_cnt + CNT_W'(1);
      if (state_reg == MEM_WAIT)  wait_cnt  <= wait_cnt + CNT_W'(1);
    end
  end
`endif

endmodule
